kernel_ir_nec_rx: RTL and testbench

//  Avalon-MM slave that decodes NEC infrared frames from the demodulated IR receiver pin.

---
 rtl/kernel_ir_nec_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_kernel_ir_nec_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_ir_nec_rx.sv
// kernel_ir_nec_rx
//   Avalon-MM slave that decodes NEC infrared frames from the demodulated,
//   active-low IR receiver pin and exposes the last frame, status, control
//   and an accepted-frame counter to the Nios kernel.
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   address[1:0]          0 DATA, 1 STATUS (W1C), 2 CTRL, 3 COUNT
//   chipselect, write_n   write strobe = chipselect & ~write_n
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read data (zero wait states)
//   ir_rx                 IR receiver output, 0 = carrier present, asynchronous
//   irq                   ctrl.irq_en & status.valid
// Parameters
//   TICK_DIV  clk cycles per timing tick
//   CNT_W     width of the saturating phase counter
//   TICK_US   microseconds represented by one tick (1 in a real system; a
//             larger value lets a fast simulation keep the same us thresholds)
module kernel_ir_nec_rx #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 14,
  parameter int TICK_US  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ir_rx,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD_L = 3'd1,
    S_LEAD_H = 3'd2,
    S_BIT_L  = 3'd3,
    S_BIT_H  = 3'd4,
    S_CHECK  = 3'd5
  } state_t;

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W:0]  CNT_SAT    = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]  TICK_STEP  = (CNT_W + 1)'(TICK_US);
  localparam logic [CNT_W-1:0] TIMEOUT_US = CNT_W'(10000);

  // True when a measured phase lies inside [lo, hi] microseconds.
  function automatic logic in_win(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (v >= CNT_W'(lo)) && (v <= CNT_W'(hi));
  endfunction

  // NEC integrity: byte 1 is ~byte 0 and byte 3 is ~byte 2.
  function automatic logic nec_ok(input logic [31:0] f);
    return (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
  endfunction

  logic             ir_meta_r, ir_sync_r, ir_prev_r;
  logic             fall_s, rise_s, edge_s, tick_s, timeout_s;
  logic [PW-1:0]    presc_r;
  logic [CNT_W-1:0] cnt_r, meas_s;
  logic [CNT_W:0]   sum_s;
  state_t           state_r, state_nxt;
  logic [4:0]       bit_idx_r;
  logic [31:0]      shreg_r, data_r;
  logic [15:0]      count_r;
  logic [3:0]       status_r, w1c_s, set_s;
  logic [1:0]       ctrl_r;
  logic             wr_s, shift_s, bit_val_s, idx_clr_s, idx_inc_s;
  logic             load_s, set_err_s, set_rep_s, set_ovr_s;
  logic             wdata_unused_s;

  assign wdata_unused_s = ^writedata[31:4];

  assign fall_s    = ir_prev_r & ~ir_sync_r;
  assign rise_s    = ~ir_prev_r & ir_sync_r;
  assign edge_s    = fall_s | rise_s;
  assign tick_s    = (presc_r == PRESC_LAST);
  assign timeout_s = (meas_s > TIMEOUT_US);
  assign wr_s      = chipselect & ~write_n;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_meta_r <= 1'b0;
      ir_sync_r <= 1'b0;
      ir_prev_r <= 1'b0;
    end else begin
      ir_meta_r <= ir_rx;
      ir_sync_r <= ir_meta_r;
      ir_prev_r <= ir_sync_r;
    end
  end

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset)       presc_r <= {PW{1'b0}};
    else if (tick_s) presc_r <= {PW{1'b0}};
    else             presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
  end

  // Phase length including the current cycle's tick, so that the value seen
  // at an edge equals the full elapsed phase; saturates at all-ones.
  always_comb begin
    sum_s = {1'b0, cnt_r} + (tick_s ? TICK_STEP : {(CNT_W+1){1'b0}});
    if (sum_s > CNT_SAT) meas_s = {CNT_W{1'b1}};
    else                 meas_s = sum_s[CNT_W-1:0];
  end

  // Phase counter: restarts on every edge.
  always_ff @(posedge clk) begin
    if (reset)       cnt_r <= {CNT_W{1'b0}};
    else if (edge_s) cnt_r <= {CNT_W{1'b0}};
    else             cnt_r <= meas_s;
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt;
  end

  // Frame FSM next state and datapath strobes. Wrong-polarity edges cannot
  // occur on a clean line but are treated as errors anyway. The stop burst's
  // falling edge ends bit 31, so its rising edge lands in IDLE and is ignored.
  always_comb begin
    state_nxt = state_r;
    shift_s   = 1'b0;
    bit_val_s = 1'b0;
    idx_clr_s = 1'b0;
    idx_inc_s = 1'b0;
    load_s    = 1'b0;
    set_err_s = 1'b0;
    set_rep_s = 1'b0;
    set_ovr_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fall_s) state_nxt = S_LEAD_L;
        else        state_nxt = S_IDLE;
      end
      S_LEAD_L: begin
        if (rise_s && in_win(meas_s, 8000, 10000)) begin
          state_nxt = S_LEAD_H;
        end else if (edge_s || timeout_s) begin
          state_nxt = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          state_nxt = S_LEAD_L;
        end
      end
      S_LEAD_H: begin
        if (fall_s && in_win(meas_s, 4000, 5000)) begin
          state_nxt = S_BIT_L;
          idx_clr_s = 1'b1;
        end else if (fall_s && in_win(meas_s, 2000, 2500)) begin
          state_nxt = S_IDLE;
          set_rep_s = 1'b1;
        end else if (edge_s || timeout_s) begin
          state_nxt = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          state_nxt = S_LEAD_H;
        end
      end
      S_BIT_L: begin
        if (rise_s && in_win(meas_s, 400, 700)) begin
          state_nxt = S_BIT_H;
        end else if (edge_s || timeout_s) begin
          state_nxt = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          state_nxt = S_BIT_L;
        end
      end
      S_BIT_H: begin
        if (fall_s && (in_win(meas_s, 400, 700) || in_win(meas_s, 1400, 1900))) begin
          shift_s   = 1'b1;
          bit_val_s = in_win(meas_s, 1400, 1900);
          if (bit_idx_r == 5'd31) begin
            state_nxt = S_CHECK;
          end else begin
            state_nxt = S_BIT_L;
            idx_inc_s = 1'b1;
          end
        end else if (edge_s || timeout_s) begin
          state_nxt = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          state_nxt = S_BIT_H;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        if (ctrl_r[1] && !nec_ok(shreg_r)) set_err_s = 1'b1;
        else if (status_r[0])              set_ovr_s = 1'b1;
        else                               load_s    = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register, bit index, accepted-frame data and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r   <= 32'h0000_0000;
      bit_idx_r <= 5'd0;
      data_r    <= 32'h0000_0000;
      count_r   <= 16'h0000;
    end else begin
      if (shift_s)        shreg_r   <= {bit_val_s, shreg_r[31:1]};
      if (idx_clr_s)      bit_idx_r <= 5'd0;
      else if (idx_inc_s) bit_idx_r <= bit_idx_r + 5'd1;
      if (load_s) begin
        data_r  <= shreg_r;
        count_r <= count_r + 16'd1;
      end
    end
  end

  assign w1c_s = (wr_s && (address == 2'd1)) ? writedata[3:0] : 4'b0000;
  assign set_s = {set_err_s, set_ovr_s, set_rep_s, load_s};

  // Status (W1C, hardware set wins) and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= 4'b0000;
      ctrl_r   <= 2'b00;
    end else begin
      status_r <= (status_r & ~w1c_s) | set_s;
      if (wr_s && (address == 2'd2)) ctrl_r <= writedata[1:0];
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      2'd0:    readdata = data_r;
      2'd1:    readdata = {28'h000_0000, status_r};
      2'd2:    readdata = {30'h0000_0000, ctrl_r};
      2'd3:    readdata = {16'h0000, count_r};
      default: readdata = 32'h0000_0000;
    endcase
  end

  assign irq = ctrl_r[0] & status_r[0];

endmodule

// File: tb/tb_kernel_ir_nec_rx.sv
// Self-checking bench for kernel_ir_nec_rx. One clock cycle represents 10 us
// (TICK_DIV=1, TICK_US=10) so whole NEC frames stay short in simulation.
module tb_kernel_ir_nec_rx;

  localparam int US_PER_CLK = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        ir_rx = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state.
  logic [31:0] m_data;
  logic [3:0]  m_status;
  logic [15:0] m_count;
  logic [1:0]  m_ctrl;
  logic [31:0] rd;

  kernel_ir_nec_rx #(.TICK_DIV(1), .CNT_W(14), .TICK_US(US_PER_CLK)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .ir_rx(ir_rx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0:       return m_data;
      1:       return {28'h0, m_status};
      2:       return {30'h0, m_ctrl};
      default: return {16'h0, m_count};
    endcase
  endfunction

  function automatic logic [31:0] rand_nec();
    logic [7:0] a, c;
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    return {~c, c, ~a, a};
  endfunction

  // Frame acceptance rules applied to the model.
  task automatic model_frame(input logic [31:0] f);
    if (m_ctrl[1] && ((f[15:8] != ~f[7:0]) || (f[31:24] != ~f[23:16]))) m_status[3] = 1'b1;
    else if (m_status[0]) m_status[2] = 1'b1;
    else begin
      m_data = f;
      m_status[0] = 1'b1;
      m_count = m_count + 16'd1;
    end
  endtask

  task automatic model_reset();
    m_data = 32'h0; m_status = 4'h0; m_count = 16'h0; m_ctrl = 2'b00;
  endtask

  task automatic hold(input logic lvl, input int us);
    ir_rx = lvl;
    repeat (us / US_PER_CLK) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    if (a == 2'd1) m_status = m_status & ~d[3:0];
    if (a == 2'd2) m_ctrl = d[1:0];
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  // bnd=1 alternates one-bit highs between 1400 and 1900 us.
  task automatic send_bits(input logic [31:0] f, input int n, input logic bnd);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, int'($urandom_range(40, 70)) * 10);
      if (f[i]) hold(1'b1, bnd ? ((i % 2 == 1) ? 1900 : 1400) : int'($urandom_range(140, 190)) * 10);
      else      hold(1'b1, int'($urandom_range(40, 70)) * 10);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input logic bnd);
    hold(1'b0, int'($urandom_range(800, 1000)) * 10);
    hold(1'b1, int'($urandom_range(400, 500)) * 10);
    send_bits(f, 32, bnd);
    hold(1'b0, 560);
    hold(1'b1, 300);
    model_frame(f);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset reg%0d got %h exp 0", a, rd); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_good_frame();
    bus_wr(2'd2, 32'h2);
    send_frame(32'hBA45FF00, 1'b0);
    bus_rd(2'd0, rd); checks++;
    if (rd !== 32'hBA45FF00) begin errors++; $display("FAIL good_data got %h exp BA45FF00", rd); end
    bus_rd(2'd3, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL good_count got %h exp 1", rd); end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL good reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL good_irq_off got %b exp 0", irq); end
    bus_wr(2'd2, 32'h3);
    #1 checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL good_irq_on got %b exp 1", irq); end
  endtask

  task automatic test_repeat();
    hold(1'b0, 9000); hold(1'b1, 2250); hold(1'b0, 560); hold(1'b1, 300);
    m_status[1] = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL repeat reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
    bus_wr(2'd1, 32'hF);
    #1 checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL repeat_irq_clr got %b exp 0", irq); end
  endtask

  task automatic test_check_en();
    send_frame(32'hBB45FF00, 1'b0);
    bus_rd(2'd1, rd); checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL chk_err got %h exp 8", rd); end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL chk reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
    bus_wr(2'd1, 32'hF);
    bus_wr(2'd2, 32'h1);
    send_frame(32'hBB45FF00, 1'b0);
    bus_rd(2'd0, rd); checks++;
    if (rd !== 32'hBB45FF00) begin errors++; $display("FAIL nochk_data got %h exp BB45FF00", rd); end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL nochk reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL nochk_irq got %b exp 1", irq); end
    bus_wr(2'd1, 32'hF);
  endtask

  task automatic test_overrun();
    logic [31:0] f1, f2;
    f1 = rand_nec(); f2 = rand_nec();
    bus_wr(2'd2, 32'h3);
    send_frame(f1, 1'b0);
    send_frame(f2, 1'b0);
    bus_rd(2'd1, rd); checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL ovr_status got %h exp 5", rd); end
    bus_rd(2'd0, rd); checks++;
    if (rd !== f1) begin errors++; $display("FAIL ovr_data got %h exp %h", rd, f1); end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL ovr reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
    bus_wr(2'd1, 32'hF);
    #1 checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq got %b exp 0", irq); end
    bus_rd(2'd1, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ovr_clr got %h exp 0", rd); end
  endtask

  task automatic test_timing();
    logic [31:0] f;
    f = rand_nec();
    send_frame(f, 1'b1);
    bus_rd(2'd0, rd); checks++;
    if (rd !== f) begin errors++; $display("FAIL bnd_1400_1900 got %h exp %h", rd, f); end
    bus_rd(2'd1, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL bnd_status got %h exp 1", rd); end
    bus_wr(2'd1, 32'hF);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        hold(1'b0, 9000); hold(1'b1, 4500); hold(1'b0, 560); hold(1'b1, 1950); hold(1'b0, 560);
      end else if (k == 1) begin
        hold(1'b0, 7990);
      end else begin
        hold(1'b0, 12000);
      end
      hold(1'b1, 300);
      m_status[3] = 1'b1;
      for (int a = 0; a < 4; a++) begin
        bus_rd(2'(a), rd); checks++;
        if (rd !== exp_reg(a)) begin errors++; $display("FAIL bnd_err%0d reg%0d got %h exp %h", k, a, rd, exp_reg(a)); end
      end
      bus_wr(2'd1, 32'hF);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] f;
    f = rand_nec();
    hold(1'b0, 9000); hold(1'b1, 4500);
    send_bits(f, 16, 1'b0);
    hold(1'b0, 300);
    reset = 1'b1; ir_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    hold(1'b1, 300);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL midrst reg%0d got %h exp 0", a, rd); end
    end
    bus_wr(2'd2, 32'h2);
    f = rand_nec();
    send_frame(f, 1'b0);
    bus_rd(2'd3, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL midrst_count got %h exp 1", rd); end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rd); checks++;
      if (rd !== exp_reg(a)) begin errors++; $display("FAIL midrst_next reg%0d got %h exp %h", a, rd, exp_reg(a)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2; n++) begin
      bus_wr(2'd1, 32'hF);
      bus_wr(2'd2, {30'h0, 1'b1, 1'($urandom_range(0, 1))});
      send_frame(rand_nec(), 1'b0);
      for (int a = 0; a < 4; a++) begin
        bus_rd(2'(a), rd); checks++;
        if (rd !== exp_reg(a)) begin errors++; $display("FAIL rand%0d reg%0d got %h exp %h", n, a, rd, exp_reg(a)); end
      end
      checks++;
      if (irq !== (m_ctrl[0] & m_status[0])) begin
        errors++; $display("FAIL rand%0d_irq got %b exp %b", n, irq, m_ctrl[0] & m_status[0]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_repeat();
    test_check_en();
    test_overrun();
    test_timing();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
